// File: rtl/resilient_stage_sched_if.sv
// Requester, stage and error-counter signals of the resilient stage scheduler.
// Latency: none, wires only.
// Backpressure: req is held by each requester until its done/fail pulse.
interface resilient_stage_sched_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] fail;
  logic             stage_go;
  logic             stage_sample;
  logic             err0;
  logic             err1;
  logic [CNT_W-1:0] err0_cnt;
  logic [CNT_W-1:0] err1_cnt;

  // Scheduler side
  modport master (
    input  req, err0, err1,
    output gnt, done, fail, stage_go, stage_sample, err0_cnt, err1_cnt
  );

  // Requesters and stage side
  modport slave (
    output req, err0, err1,
    input  gnt, done, fail, stage_go, stage_sample, err0_cnt, err1_cnt
  );
endinterface

// File: rtl/resilient_stage_sched.sv
// Round-robin scheduler sharing one timing-error-resilient stage; replays on err0/err1.
// Latency: req seen in IDLE at k -> go k+1, sample k+2, done k+3; each error adds 2+PEN.
// Backpressure: requesters hold req until done/fail; optional error counters via SCHED_ERR_CNT_EN.
module resilient_stage_sched #(
  parameter int N_REQ     = 4,
  parameter int ERR0_PEN  = 1,
  parameter int ERR1_PEN  = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  resilient_stage_sched_if.master bus
);

  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int PEN_MAX = (ERR1_PEN > ERR0_PEN) ? ERR1_PEN : ERR0_PEN;
  localparam int PW      = $clog2(PEN_MAX + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [2:0] {IDLE, LAUNCH, SAMPLE, RECOVER, RELEASE} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    owner, owner_nx;
  logic [IW-1:0]    last_grant, last_nx;
  logic [RW-1:0]    retry, retry_nx;
  logic [PW-1:0]    pen, pen_nx;
  logic             done_set, fail_set;
  logic             err_hit, err1_hit;
  logic             found;
  logic [IW-1:0]    win;
  int               idx;

  logic [N_REQ-1:0] gnt_q, done_q, fail_q;
  logic             go_q, smp_q;

  // Round-robin search starting just after the last new grant
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!found && bus.req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, retry/penalty bookkeeping and completion decisions
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last_grant;
    retry_nx = retry;
    pen_nx   = pen;
    done_set = 1'b0;
    fail_set = 1'b0;
    err_hit  = 1'b0;
    err1_hit = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = LAUNCH;
          owner_nx = win;
          last_nx  = win;
          retry_nx = '0;
        end
      end
      LAUNCH: state_nx = SAMPLE;
      SAMPLE: begin
        // err1 takes precedence when both flags are raised
        err_hit  = bus.err0 | bus.err1;
        err1_hit = bus.err1;
        if (!err_hit) begin
          state_nx = RELEASE;
          done_set = 1'b1;
        end else if (retry == RW'(MAX_RETRY)) begin
          state_nx = RELEASE;
          fail_set = 1'b1;
        end else begin
          state_nx = RECOVER;
          retry_nx = retry + RW'(1);
          pen_nx   = err1_hit ? PW'(ERR1_PEN - 1) : PW'(ERR0_PEN - 1);
        end
      end
      RECOVER: begin
        if (pen == '0) state_nx = LAUNCH;
        else           pen_nx   = pen - PW'(1);
      end
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= '0;
      last_grant <= IW'(N_REQ - 1);
      retry      <= '0;
      pen        <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      go_q       <= 1'b0;
      smp_q      <= 1'b0;
    end else begin
      owner      <= owner_nx;
      last_grant <= last_nx;
      retry      <= retry_nx;
      pen        <= pen_nx;
      gnt_q      <= (state_nx != IDLE) ? (ONE << owner_nx) : '0;
      done_q     <= done_set ? (ONE << owner) : '0;
      fail_q     <= fail_set ? (ONE << owner) : '0;
      go_q       <= (state_nx == LAUNCH);
      smp_q      <= (state_nx == SAMPLE);
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.stage_go     = go_q;
  assign bus.stage_sample = smp_q;

`ifdef SCHED_ERR_CNT_EN
  logic [CNT_W-1:0] e0_cnt, e1_cnt;

  // Saturating error-event counters, bumped on the sample cycle only
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_cnt <= '0;
      e1_cnt <= '0;
    end else begin
      if (err_hit && err1_hit && (e1_cnt != '1))  e1_cnt <= e1_cnt + CNT_W'(1);
      if (err_hit && !err1_hit && (e0_cnt != '1)) e0_cnt <= e0_cnt + CNT_W'(1);
    end
  end

  assign bus.err0_cnt = e0_cnt;
  assign bus.err1_cnt = e1_cnt;
`else
  assign bus.err0_cnt = '0;
  assign bus.err1_cnt = '0;
`endif

endmodule

// File: tb/tb_resilient_stage_sched.sv
// Self-checking bench for resilient_stage_sched: scoreboard of done/fail events.
// Latency: cycle 0 is the first cycle the DUT sees a new req after reset.
// Backpressure: modelled requesters drop req on their done/fail pulse.
module tb_resilient_stage_sched;
  localparam int N_REQ = 4;
  localparam int CNT_W = 16;
`ifdef SCHED_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  resilient_stage_sched_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus();

  resilient_stage_sched #(
    .N_REQ(N_REQ), .ERR0_PEN(1), .ERR1_PEN(4), .MAX_RETRY(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int idx; bit is_fail;} ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [1:0] err_pat[$];   // {err1, err0} per stage_sample, in order
  int         cyc, go_cnt, n_tests, n_fail;
  bit         auto_drop, junk;

  function automatic int exp_cnt(input int v);
    return CNT_ON ? v : 0;
  endfunction

  // One clock: observe outputs at the falling edge, then drive err flags and requester reactions
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    cyc++;
    if (bus.stage_go) go_cnt++;
    if (bus.stage_sample) begin
      e = (err_pat.size() > 0) ? err_pat.pop_front() : 2'b00;
      bus.err0 = e[0];
      bus.err1 = e[1];
    end else if (junk) begin
      bus.err0 = 1'($urandom_range(0, 1));
      bus.err1 = 1'($urandom_range(0, 1));
    end else begin
      bus.err0 = 1'b0;
      bus.err1 = 1'b0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.done[i]) begin
        obs_q.push_back('{cyc: cyc, idx: i, is_fail: 1'b0});
        if (auto_drop) bus.req[i] = 1'b0;
      end
      if (bus.fail[i]) begin
        obs_q.push_back('{cyc: cyc, idx: i, is_fail: 1'b1});
        if (auto_drop) bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    bus.req  = '0;
    bus.err0 = 1'b0;
    bus.err1 = 1'b0;
    err_pat.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    cyc       = 0;
    go_cnt    = 0;
    auto_drop = 1'b1;
    junk      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.fail !== 4'b0 ||
        bus.stage_go !== 1'b0 || bus.stage_sample !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b fail=%b go=%b smp=%b, want all 0",
               bus.gnt, bus.done, bus.fail, bus.stage_go, bus.stage_sample);
    end
    n_tests++;
    if (bus.err0_cnt !== 16'd0 || bus.err1_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: err0_cnt=%0d err1_cnt=%0d, want 0/0", bus.err0_cnt, bus.err1_cnt);
    end
    repeat (2) step();
    n_tests++;
    if (bus.gnt !== 4'b0 || go_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b go_cnt=%0d with no req, want 0000/0", bus.gnt, go_cnt);
    end
  endtask

  task automatic test_single();
    ev_t e, o;
    do_reset();
    bus.req = 4'b0001;
    exp_q.push_back('{cyc: 3, idx: 0, is_fail: 1'b0});
    repeat (6) begin
      step();
      if (cyc == 1) begin
        n_tests++;
        if (bus.gnt !== 4'b0001 || bus.stage_go !== 1'b1) begin
          n_fail++;
          $display("FAIL single_launch: gnt=%b go=%b, want 0001/1", bus.gnt, bus.stage_go);
        end
      end
      if (cyc == 2) begin
        n_tests++;
        if (bus.stage_sample !== 1'b1 || bus.stage_go !== 1'b0) begin
          n_fail++;
          $display("FAIL single_sample: smp=%b go=%b, want 1/0", bus.stage_sample, bus.stage_go);
        end
      end
      if (cyc == 4) begin
        n_tests++;
        if (bus.gnt !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_gnt_clear: gnt=%b, want 0000", bus.gnt);
        end
      end
    end
    n_tests++;
    if (go_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_go_count: got %0d, want 1", go_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL single_sb: no event, want idx %0d fail=%0d at cycle %0d", e.idx, e.is_fail, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL single_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL single_extra: %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_req_drop();
    ev_t e, o;
    do_reset();
    bus.req = 4'b0001;
    exp_q.push_back('{cyc: 3, idx: 0, is_fail: 1'b0});
    repeat (6) begin
      step();
      if (cyc == 1) bus.req = 4'b0000;
      if (cyc == 2) begin
        n_tests++;
        if (bus.gnt !== 4'b0001) begin
          n_fail++;
          $display("FAIL drop_gnt_held: gnt=%b, want 0001", bus.gnt);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL drop_sb: no event, want idx %0d at cycle %0d", e.idx, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL drop_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
  endtask

  task automatic test_fairness();
    ev_t        e, o;
    logic [3:0] g;
    do_reset();
    auto_drop = 1'b0;
    bus.req   = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back('{cyc: 3 + 4 * k, idx: k % 4, is_fail: 1'b0});
    repeat (24) begin
      step();
      if (cyc % 4 == 1 && cyc <= 17) begin
        g = 4'b0001 << ((cyc / 4) % 4);
        n_tests++;
        if (bus.gnt !== g) begin
          n_fail++;
          $display("FAIL fair_gnt: cycle %0d gnt=%b, want %b", cyc, bus.gnt, g);
        end
      end
      if (cyc == 19) bus.req = 4'b0000;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fair_sb: no event, want idx %0d at cycle %0d", e.idx, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL fair_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL fair_extra: %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_err0_retry();
    ev_t e, o;
    do_reset();
    err_pat.push_back(2'b01);
    bus.req = 4'b0001;
    exp_q.push_back('{cyc: 6, idx: 0, is_fail: 1'b0});
    repeat (8) step();
    n_tests++;
    if (go_cnt !== 2) begin
      n_fail++;
      $display("FAIL err0_go_count: got %0d, want 2", go_cnt);
    end
    n_tests++;
    if (bus.err0_cnt !== 16'(exp_cnt(1)) || bus.err1_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL err0_counters: err0_cnt=%0d err1_cnt=%0d, want %0d/0",
               bus.err0_cnt, bus.err1_cnt, exp_cnt(1));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL err0_sb: no event, want idx %0d at cycle %0d", e.idx, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL err0_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
  endtask

  task automatic test_both_err();
    ev_t e, o;
    do_reset();
    junk = 1'b1;   // flags toggle randomly outside SAMPLE and must be ignored
    err_pat.push_back(2'b11);
    bus.req = 4'b0001;
    exp_q.push_back('{cyc: 9, idx: 0, is_fail: 1'b0});
    repeat (11) step();
    junk = 1'b0;
    n_tests++;
    if (go_cnt !== 2) begin
      n_fail++;
      $display("FAIL both_go_count: got %0d, want 2", go_cnt);
    end
    n_tests++;
    if (bus.err1_cnt !== 16'(exp_cnt(1)) || bus.err0_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL both_counters: err0_cnt=%0d err1_cnt=%0d, want 0/%0d",
               bus.err0_cnt, bus.err1_cnt, exp_cnt(1));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL both_sb: no event, want idx %0d at cycle %0d", e.idx, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL both_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL both_extra: %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_retry_exhaust();
    ev_t e, o;
    do_reset();
    repeat (4) err_pat.push_back(2'b10);
    bus.req = 4'b0011;
    exp_q.push_back('{cyc: 21, idx: 0, is_fail: 1'b1});
    exp_q.push_back('{cyc: 25, idx: 1, is_fail: 1'b0});
    repeat (27) begin
      step();
      if (cyc == 21) begin
        n_tests++;
        if (go_cnt !== 4) begin
          n_fail++;
          $display("FAIL exhaust_go_count: got %0d at fail, want 4", go_cnt);
        end
      end
      if (cyc == 23) begin
        n_tests++;
        if (bus.gnt !== 4'b0010) begin
          n_fail++;
          $display("FAIL exhaust_next_gnt: gnt=%b, want 0010", bus.gnt);
        end
      end
    end
    n_tests++;
    if (bus.err1_cnt !== 16'(exp_cnt(4)) || bus.err0_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL exhaust_counters: err0_cnt=%0d err1_cnt=%0d, want 0/%0d",
               bus.err0_cnt, bus.err1_cnt, exp_cnt(4));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL exhaust_sb: no event, want idx %0d fail=%0d at cycle %0d", e.idx, e.is_fail, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL exhaust_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL exhaust_extra: %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  task automatic test_reset_recover();
    ev_t e, o;
    do_reset();
    err_pat.push_back(2'b10);
    bus.req = 4'b0001;
    repeat (4) step();   // now in cycle 4, inside the err1 recovery window
    rst = 1'b1;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0 || bus.done !== 4'b0 || bus.fail !== 4'b0 ||
        bus.stage_go !== 1'b0 || bus.stage_sample !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrec_outputs: gnt=%b done=%b fail=%b go=%b smp=%b, want all 0",
               bus.gnt, bus.done, bus.fail, bus.stage_go, bus.stage_sample);
    end
    n_tests++;
    if (bus.err1_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rstrec_counter: err1_cnt=%0d, want 0", bus.err1_cnt);
    end
    rst     = 1'b0;
    bus.req = 4'b0011;
    exp_q.push_back('{cyc: 8, idx: 0, is_fail: 1'b0});
    exp_q.push_back('{cyc: 12, idx: 1, is_fail: 1'b0});
    repeat (8) begin
      step();
      if (cyc == 6) begin
        n_tests++;
        if (bus.gnt !== 4'b0001) begin
          n_fail++;
          $display("FAIL rstrec_first_gnt: gnt=%b, want 0001", bus.gnt);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL rstrec_sb: no event, want idx %0d at cycle %0d", e.idx, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.idx !== e.idx || o.is_fail !== e.is_fail) begin
          n_fail++;
          $display("FAIL rstrec_sb: got idx %0d fail=%0d cyc %0d, want idx %0d fail=%0d cyc %0d",
                   o.idx, o.is_fail, o.cyc, e.idx, e.is_fail, e.cyc);
        end
      end
    end
    n_tests++;
    if (obs_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rstrec_extra: %0d unexpected events, want 0", obs_q.size());
    end
  endtask

  initial begin
    bus.req   = '0;
    bus.err0  = 1'b0;
    bus.err1  = 1'b0;
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    go_cnt    = 0;
    auto_drop = 1'b1;
    junk      = 1'b0;
    test_reset();
    test_single();
    test_req_drop();
    test_fairness();
    test_err0_retry();
    test_both_err();
    test_retry_exhaust();
    test_reset_recover();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/resilient_stage_sched.md
# resilient_stage_sched

Synchronous scheduler that shares one timing-error-resilient datapath stage among N_REQ requesters. It grants the stage round-robin, launches and samples each operation, and reads the stage's two error flags at sample time. On an error it stalls for a flag-dependent recovery penalty and replays the operation, up to a retry limit. It sits between the requester ports and the stage's launch, sample and error interface.

## Interface
- N_REQ, 4: number of requesters (2..8).
- ERR0_PEN, 1: recovery stall cycles after a short-path error (err0 only); ≥1.
- ERR1_PEN, 4: recovery stall cycles after a long-path error (err1); ≥1.
- MAX_RETRY, 3: replays allowed per operation; total attempts = MAX_RETRY+1.
- CNT_W, 16: width of error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until that requester's done or fail pulse.
- gnt  out  N_REQ  one-hot grant; registered.
- done  out  N_REQ  one-cycle pulse: granted op completed without error.
- fail  out  N_REQ  one-cycle pulse: op abandoned after retries exhausted.
- stage_go  out  1  one-cycle launch pulse to the stage.
- stage_sample  out  1  one-cycle sample pulse; err0/err1 are valid in this cycle only.
- err0  in  1  short-path timing error flag.
- err1  in  1  long-path timing error flag.
- err0_cnt  out  CNT_W  saturating count of err0-only events.
- err1_cnt  out  CNT_W  saturating count of err1 events.

## Operation
- Every state register, flag and pulse is registered.
- States and transitions:
  - IDLE: if any req, pick winner → LAUNCH; else stay.
  - LAUNCH: stage_go=1 → SAMPLE.
  - SAMPLE: stage_sample=1.
    - No error → RELEASE(ok).
    - Error and retry<MAX_RETRY → RECOVER; retry++.
    - Error and retry==MAX_RETRY → RELEASE(fail).
  - RECOVER: count down the penalty, then → LAUNCH (replay, same grantee).
  - RELEASE: pulse done or fail on the grantee bit → IDLE.
- Error precedence: err1 wins when both flags are high. Penalty = ERR1_PEN and err1_cnt increments. Otherwise err0 → ERR0_PEN and err0_cnt increments. Flags outside SAMPLE are ignored.
- Round-robin: search starts at last_grant+1, mod N_REQ. last_grant updates on entry to LAUNCH from IDLE only; replays do not rotate it.
- gnt is high from LAUNCH through RELEASE inclusive and low in IDLE. The winner is latched; gnt never changes mid-operation.
- retry clears on every new grant.
- A req dropped mid-operation has no effect; the op runs to done/fail.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset (sync, in effect from the first edge with rst=1):
  - State=IDLE, gnt=0, done=0, fail=0, stage_go=0, stage_sample=0.
  - retry=0, counters=0, last_grant=N_REQ−1, so requester 0 wins first.
- Reset mid-operation aborts with no done/fail pulse.
- Error-free latency: req seen in IDLE at cycle k.
  - LAUNCH (gnt, stage_go) in k+1.
  - SAMPLE in k+2.
  - RELEASE (done) in k+3.
  - IDLE in k+4.
  - Back-to-back throughput: one op per 4 cycles.
- Each error adds 2+PEN cycles: PEN RECOVER cycles, then LAUNCH and SAMPLE again.
- Worst case with all-err1: 4 + MAX_RETRY·(2+ERR1_PEN) cycles, ending in fail.

## Configuration
- SCHED_ERR_CNT_EN
  - Defined: err0_cnt and err1_cnt implemented as specified.
  - Undefined: counter logic omitted; both outputs tied to 0. Scheduling behaviour is identical either way.

## Test plan
- Single requester, no errors: req[0]=1 at cycle 0 → stage_go at 1, stage_sample at 2, done[0] at 3, gnt back to 0 at 4.
- Fairness: req=4'b1111 held, no errors → grants in order 0,1,2,3,0, each 4 cycles apart.
- err0 on first sample, clean retry: done at cycle 3+1+2=6, with two stage_go pulses. With SCHED_ERR_CNT_EN: err0_cnt=1, err1_cnt=0.
- err0 and err1 together on first sample: ERR1_PEN=4 applied, done at cycle 9, err1_cnt=1, err0_cnt=0.
- err1 forced on every sample: 4 stage_go pulses, fail[0] at cycle 3+3·6=21, no done. The next requester is granted afterwards.
- rst asserted during RECOVER → next cycle gnt=0, state IDLE, no pulses. After release, requester 0 is granted first.
